id_ex_skid_stage: RTL
=====================

# id_ex_skid_stage

Parametrised ID/EX pipeline stage for the pipelined CPU, sitting between decode (register read, sign extend, control decode) and execute. It carries operand data, register addresses, the immediate and the M/EX/WB control groups, as the plain ID/EX register does. It adds a valid/ready handshake with a two-entry skid buffer, so execute can stall without a combinational ready path back into decode. It also supports flush-to-bubble on branch/hazard and a saturating stall-cycle counter.

## Interface
- XLEN, 32, operand/immediate width
- RAW, 5, register address width
- M_W, 2, M (memory) control group width
- EX_W, 4, EX control group width
- WB_W, 2, WB control group width
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming content; insert bubble
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  stage can accept; driven directly from a flop
- in_rs_data, in_rt_data  in  XLEN  register-file read data
- in_rd_addr, in_rt_addr  in  RAW  destination / rt addresses
- in_imm  in  XLEN  sign-extended immediate
- in_m, in_ex, in_wb  in  M_W / EX_W / WB_W  control groups
- out_valid  out  1  execute-side content valid
- out_ready  in  1  execute accepts this cycle
- out_rs_data, out_rt_data, out_rd_addr, out_rt_addr, out_imm, out_m, out_ex, out_wb  out  same widths as inputs  registered bundle
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main register (drives out_*) plus one skid register, each with a valid bit.
- Accept = in_valid & in_ready & !flush. Output transfer = out_valid & out_ready.
- in_ready = !skid_valid.
- Main empty, or main transferring with skid empty: accepted bundle loads into main.
- Main full, not transferring, accept: bundle loads into skid; in_ready drops next cycle.
- Main transferring, skid full: skid moves to main, skid empties. No accept is possible, since in_ready=0.
- Main transferring, nothing to load: out_valid→0. out_m/out_ex/out_wb→0 (bubble). Data fields hold.
- Whenever out_valid=0, out_m, out_ex and out_wb are 0. The execute stage must never see stale control.
- flush: next cycle out_valid=0, skid_valid=0, control fields 0, in_ready=1. A same-cycle in_valid is dropped. Flush overrides every other event, including a simultaneous out_ready transfer (that transfer still counts as taken by execute).
- stall_cnt: increments when out_valid & !out_ready, holds at 2^CNT_W−1, unaffected by flush.

## Timing
- Latency: accept in cycle N → out_valid with that bundle in N+1.
- Throughput: 1 bundle/cycle while out_ready=1 continuously.
- out_ready low for k cycles: at most one extra bundle is absorbed (skid), then in_ready=0 from the following cycle. After out_ready rises, in_ready returns to 1 one cycle after the skid drains.
- Order is strictly preserved: skid content always leaves before any later accept.
- Reset (any cycle, including mid-stall): next edge sets all out_* to 0, out_valid=0, skid empty, in_ready=1, stall_cnt=0.
- No combinational path from out_ready or in_valid to in_ready. out_* are pure flop outputs.

## Structure
- Package id_ex_pkg holds the default width constants and the packed struct id_ex_bundle_t (rs_data, rt_data, rd_addr, rt_addr, imm, m, ex, wb), in that field order.
- Sub-module pipe_skid_reg #(W): a generic two-entry skid register with flush, carrying the packed bundle. It is reused later for EX/MEM.
- The top level handles bundle pack/unpack, bubble control-zeroing and stall_cnt.

## Test plan
- Streaming: out_ready=1, 8 back-to-back bundles (rs_data=0x10..0x17) → identical bundles on out_* one cycle later, no gaps, in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles while sending A, B, C → A held on out, B in skid, C stalled by in_ready=0 from the next cycle. After release, output order is A, B, C and stall_cnt=3.
- Flush with full skid: A in main, B in skid, flush=1 with in_valid (D) → next cycle out_valid=0, out_ex=0, in_ready=1, and D is never output.
- Bubble: single bundle with in_wb=2'b11 and out_ready=1 → out_wb=2'b11 for one cycle, then out_valid=0 with out_wb=0.
- Reset mid-stall: skid full and stall_cnt=5, rst=1 → next cycle all outputs 0, stall_cnt=0, in_ready=1.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 → stall_cnt holds at 15.

Source files
------------

// File: rtl/id_ex_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_pkg
//
// Shared definitions for the ID/EX pipeline stage.
//   - Default width constants for operands, register addresses, control groups
//     and the stall counter.
//   - id_ex_bundle_t: the packed ID/EX bundle at default widths. Field order is
//     fixed (rs_data, rt_data, rd_addr, rt_addr, imm, m, ex, wb), so the control
//     groups occupy the least-significant bits.
//   - id_ex_bundle_w(): bundle width for arbitrary parameter values. The
//     parametrised top packs its bundle in the same field order.
// -----------------------------------------------------------------------------
package id_ex_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned RAW_DEF   = 5;
    localparam int unsigned M_W_DEF   = 2;
    localparam int unsigned EX_W_DEF  = 4;
    localparam int unsigned WB_W_DEF  = 2;
    localparam int unsigned CNT_W_DEF = 16;

    typedef struct packed {
        logic [XLEN_DEF-1:0] rs_data;
        logic [XLEN_DEF-1:0] rt_data;
        logic [RAW_DEF-1:0]  rd_addr;
        logic [RAW_DEF-1:0]  rt_addr;
        logic [XLEN_DEF-1:0] imm;
        logic [M_W_DEF-1:0]  m;
        logic [EX_W_DEF-1:0] ex;
        logic [WB_W_DEF-1:0] wb;
    } id_ex_bundle_t;

    localparam int unsigned ID_EX_BUNDLE_W = $bits(id_ex_bundle_t);

    // Width of the packed bundle for a given set of field widths.
    function automatic int unsigned id_ex_bundle_w(input int unsigned xlen,
                                                   input int unsigned raw,
                                                   input int unsigned m_w,
                                                   input int unsigned ex_w,
                                                   input int unsigned wb_w);
        return 3 * xlen + 2 * raw + m_w + ex_w + wb_w;
    endfunction

    // Width of the control groups, which sit in the low bits of the bundle.
    function automatic int unsigned id_ex_ctrl_w(input int unsigned m_w,
                                                 input int unsigned ex_w,
                                                 input int unsigned wb_w);
        return m_w + ex_w + wb_w;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Generic two-entry skid register with flush. A main register drives the
// output. A skid register absorbs the one bundle that arrives in the cycle
// after the consumer stalls, so in_ready can come straight from a flop.
//
// Parameters
//   W          payload width
//   ClearMask  payload bits forced to 0 whenever the main entry becomes
//              empty (bubble). Unmasked bits hold their last value.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   flush      drop main, skid and any same-cycle input; main becomes a bubble
//   in_valid   producer offers in_data
//   in_ready   stage can accept (registered)
//   in_data    incoming payload
//   out_valid  main entry holds valid payload
//   out_ready  consumer takes out_data this cycle
//   out_data   main entry payload (registered)
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int unsigned    W         = 8,
    parameter logic [W-1:0]   ClearMask = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;

    logic accept;
    logic xfer;

    assign accept = in_valid & in_ready_q & ~flush;
    assign xfer   = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            // Flush wins over everything, including a simultaneous transfer.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = main_q & ~ClearMask;
        end else if (!main_valid_q || xfer) begin
            // Main is free next cycle: refill from skid first to keep order.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
                main_d       = main_q & ~ClearMask;
            end
        end else if (accept) begin
            // Main stalled: park the bundle in skid, in_ready drops next cycle.
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// -----------------------------------------------------------------------------
// id_ex_skid_stage
//
// ID/EX pipeline stage with valid/ready handshake, two-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
//
// Ports
//   clk, rst                   clock and synchronous active-high reset
//   flush                      discard held and incoming content, insert bubble
//   in_valid / in_ready        decode-side handshake (in_ready is registered)
//   in_rs_data, in_rt_data     register-file read data
//   in_rd_addr, in_rt_addr     destination / rt register addresses
//   in_imm                     sign-extended immediate
//   in_m, in_ex, in_wb         control groups
//   out_valid / out_ready      execute-side handshake
//   out_*                      registered bundle; control groups 0 on a bubble
//   stall_cnt                  cycles with out_valid & !out_ready, saturating
// -----------------------------------------------------------------------------
module id_ex_skid_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned RAW   = RAW_DEF,
    parameter int unsigned M_W   = M_W_DEF,
    parameter int unsigned EX_W  = EX_W_DEF,
    parameter int unsigned WB_W  = WB_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs_data,
    input  logic [XLEN-1:0]  in_rt_data,
    input  logic [RAW-1:0]   in_rd_addr,
    input  logic [RAW-1:0]   in_rt_addr,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [M_W-1:0]   in_m,
    input  logic [EX_W-1:0]  in_ex,
    input  logic [WB_W-1:0]  in_wb,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rs_data,
    output logic [XLEN-1:0]  out_rt_data,
    output logic [RAW-1:0]   out_rd_addr,
    output logic [RAW-1:0]   out_rt_addr,
    output logic [XLEN-1:0]  out_imm,
    output logic [M_W-1:0]   out_m,
    output logic [EX_W-1:0]  out_ex,
    output logic [WB_W-1:0]  out_wb,

    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned BW  = id_ex_bundle_w(XLEN, RAW, M_W, EX_W, WB_W);
    localparam int unsigned CW  = id_ex_ctrl_w(M_W, EX_W, WB_W);

    // Control groups sit in the low CW bits; only they are zeroed on a bubble.
    localparam logic [BW-1:0] CtrlMask = {{(BW - CW){1'b0}}, {CW{1'b1}}};

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [BW-1:0] in_bundle;
    logic [BW-1:0] out_bundle;

    assign in_bundle = {in_rs_data, in_rt_data, in_rd_addr, in_rt_addr,
                        in_imm, in_m, in_ex, in_wb};

    pipe_skid_reg #(
        .W         (BW),
        .ClearMask (CtrlMask)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bundle)
    );

    assign {out_rs_data, out_rt_data, out_rd_addr, out_rt_addr,
            out_imm, out_m, out_ex, out_wb} = out_bundle;

    // Stall counter: counts back-pressure cycles regardless of flush.
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
